// File: rtl/sd_pkg.sv
// Shared types and defaults for the SD card access controller.
package sd_pkg;

  localparam int unsigned TIMEOUT_DEF        = 200000;
  localparam int unsigned RECOVER_CYCLES_DEF = 2;
  localparam int unsigned RELEASE_CYCLES     = 2;

  // One-hot controller states
  typedef enum logic [5:0] {
    INIT_WAIT = 6'b000001,
    IDLE      = 6'b000010,
    RD_RUN    = 6'b000100,
    WR_RUN    = 6'b001000,
    RELEASE   = 6'b010000,
    RECOVER   = 6'b100000
  } sd_state_t;

  // Which engine owns the card bus
  typedef enum logic {
    OWN_RD = 1'b0,
    OWN_WR = 1'b1
  } sd_owner_t;

endpackage

// File: rtl/sd_rr_arb.sv
// Two-requester round-robin arbiter; read wins the first tie after reset.
module sd_rr_arb
  import sd_pkg::*;
(
  input  logic sdclk,
  input  logic reset,
  input  logic en,
  input  logic req_rd,
  input  logic req_wr,
  output logic gnt_rd,
  output logic gnt_wr
);

  sd_owner_t last;

  // On a tie, grant the class that did not win the previous grant
  always_comb begin
    gnt_rd = en & req_rd & (~req_wr | (last == OWN_WR));
    gnt_wr = en & req_wr & (~req_rd | (last == OWN_RD));
  end

  // Remember the class of the most recent grant
  always_ff @(posedge sdclk or posedge reset) begin
    if (reset) begin
      last <= OWN_WR;
    end else if (gnt_rd) begin
      last <= OWN_RD;
    end else if (gnt_wr) begin
      last <= OWN_WR;
    end
  end

endmodule

// File: rtl/sd_access_ctrl.sv
// Arbitrates sector read/write requests onto the SD read/write engines,
// muxes the owning engine's SPI lines to the card, and supervises each
// transaction with a timeout and an engine-reset recovery window.
module sd_access_ctrl
  import sd_pkg::*;
#(
  parameter int unsigned TIMEOUT        = TIMEOUT_DEF,
  parameter int unsigned RECOVER_CYCLES = RECOVER_CYCLES_DEF
) (
  input  logic        sdclk,
  input  logic        reset,
  input  logic        init_done,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [31:0] rd_addr,
  input  logic [31:0] wr_addr,
  output logic        rd_ack,
  output logic        wr_ack,
  output logic        rd_fail,
  output logic        wr_fail,
  output logic [31:0] eng_addr,
  output logic        eng_re,
  output logic        eng_we,
  input  logic        rend,
  input  logic        rerr,
  input  logic        wend,
  input  logic        werr,
  input  logic        rd_cs,
  input  logic        rd_din,
  input  logic        wr_cs,
  input  logic        wr_din,
  output logic        cs,
  output logic        din,
  output logic        eng_rst,
  output logic        busy
);

  sd_state_t   state;
  sd_state_t   state_next;
  sd_owner_t   owner;
  logic [31:0] cnt;
  logic        arb_en;
  logic        gnt_rd;
  logic        gnt_wr;
  logic        run_done;
  logic        run_fail;

  assign arb_en = (state == IDLE) && init_done;

  sd_rr_arb u_arb (
    .sdclk  (sdclk),
    .reset  (reset),
    .en     (arb_en),
    .req_rd (rd_req),
    .req_wr (wr_req),
    .gnt_rd (gnt_rd),
    .gnt_wr (gnt_wr)
  );

  // Exit conditions of the running transaction; error and timeout both fail
  always_comb begin
    run_done = (state == WR_RUN) ? wend : rend;
    run_fail = ((state == WR_RUN) ? werr : rerr) || (cnt == TIMEOUT - 1);
  end

  // Next-state and completion pulses; ack only in the RUN exit cycle
  always_comb begin
    state_next = state;
    rd_ack     = 1'b0;
    wr_ack     = 1'b0;
    rd_fail    = 1'b0;
    wr_fail    = 1'b0;
    case (state)
      INIT_WAIT: begin
        if (init_done) state_next = IDLE;
      end
      IDLE: begin
        if (!init_done)  state_next = INIT_WAIT;
        else if (gnt_rd) state_next = RD_RUN;
        else if (gnt_wr) state_next = WR_RUN;
      end
      RD_RUN, WR_RUN: begin
        if (run_fail || run_done) begin
          state_next = run_fail ? RECOVER : RELEASE;
          if (state == RD_RUN) begin
            rd_ack  = 1'b1;
            rd_fail = run_fail;
          end else begin
            wr_ack  = 1'b1;
            wr_fail = run_fail;
          end
        end
      end
      RELEASE: begin
        if (cnt == RELEASE_CYCLES - 1) state_next = IDLE;
      end
      RECOVER: begin
        if (cnt == RECOVER_CYCLES - 1) state_next = IDLE;
      end
      default: state_next = INIT_WAIT;
    endcase
  end

  // State register
  always_ff @(posedge sdclk or posedge reset) begin
    if (reset) state <= INIT_WAIT;
    else       state <= state_next;
  end

  // Grant capture and a shared cycle counter restarted on every state change
  always_ff @(posedge sdclk or posedge reset) begin
    if (reset) begin
      eng_addr <= '0;
      owner    <= OWN_RD;
      cnt      <= '0;
    end else begin
      if (state == IDLE && state_next == RD_RUN) begin
        eng_addr <= rd_addr;
        owner    <= OWN_RD;
      end else if (state == IDLE && state_next == WR_RUN) begin
        eng_addr <= wr_addr;
        owner    <= OWN_WR;
      end
      if (state_next != state) begin
        cnt <= '0;
      end else if (state == RD_RUN || state == WR_RUN ||
                   state == RELEASE || state == RECOVER) begin
        cnt <= cnt + 32'd1;
      end
    end
  end

  // Engine enables, engine reset, busy and the card SPI mux
  always_comb begin
    eng_re  = (state == RD_RUN);
    eng_we  = (state == WR_RUN);
    eng_rst = reset || (state == RECOVER);
    busy    = (state != IDLE);
    cs      = 1'b1;
    din     = 1'b1;
    if (state == RD_RUN || state == WR_RUN ||
        state == RELEASE || state == RECOVER) begin
      cs  = (owner == OWN_WR) ? wr_cs  : rd_cs;
      din = (owner == OWN_WR) ? wr_din : rd_din;
    end
  end

endmodule

// File: tb/tb_sd_access_ctrl.sv
// Self-checking bench for sd_access_ctrl: directed scenarios plus a
// randomized transaction stream checked against a round-robin model.
module tb_sd_access_ctrl;

  logic        sdclk = 1'b0;
  logic        reset, init_done, rd_req, wr_req;
  logic [31:0] rd_addr, wr_addr;
  logic        rend, rerr, wend, werr, rd_cs, rd_din, wr_cs, wr_din;

  logic        rd_ack, wr_ack, rd_fail, wr_fail, eng_re, eng_we, cs, din, eng_rst, busy;
  logic [31:0] eng_addr;
  logic        t_rd_ack, t_wr_ack, t_rd_fail, t_wr_fail, t_eng_re, t_eng_we;
  logic        t_cs, t_din, t_eng_rst, t_busy;
  logic [31:0] t_eng_addr;

  int checks   = 0;
  int failures = 0;

  always #5 sdclk = ~sdclk;

  sd_access_ctrl #(.TIMEOUT(6000), .RECOVER_CYCLES(2)) dut (
    .sdclk(sdclk), .reset(reset), .init_done(init_done),
    .rd_req(rd_req), .wr_req(wr_req), .rd_addr(rd_addr), .wr_addr(wr_addr),
    .rd_ack(rd_ack), .wr_ack(wr_ack), .rd_fail(rd_fail), .wr_fail(wr_fail),
    .eng_addr(eng_addr), .eng_re(eng_re), .eng_we(eng_we),
    .rend(rend), .rerr(rerr), .wend(wend), .werr(werr),
    .rd_cs(rd_cs), .rd_din(rd_din), .wr_cs(wr_cs), .wr_din(wr_din),
    .cs(cs), .din(din), .eng_rst(eng_rst), .busy(busy)
  );

  sd_access_ctrl #(.TIMEOUT(50), .RECOVER_CYCLES(2)) dut_t (
    .sdclk(sdclk), .reset(reset), .init_done(init_done),
    .rd_req(rd_req), .wr_req(wr_req), .rd_addr(rd_addr), .wr_addr(wr_addr),
    .rd_ack(t_rd_ack), .wr_ack(t_wr_ack), .rd_fail(t_rd_fail), .wr_fail(t_wr_fail),
    .eng_addr(t_eng_addr), .eng_re(t_eng_re), .eng_we(t_eng_we),
    .rend(rend), .rerr(rerr), .wend(wend), .werr(werr),
    .rd_cs(rd_cs), .rd_din(rd_din), .wr_cs(wr_cs), .wr_din(wr_din),
    .cs(t_cs), .din(t_din), .eng_rst(t_eng_rst), .busy(t_busy)
  );

  task automatic clear_inputs;
    init_done = 1'b0; rd_req = 1'b0; wr_req = 1'b0; rd_addr = '0; wr_addr = '0;
    rend = 1'b0; rerr = 1'b0; wend = 1'b0; werr = 1'b0;
    rd_cs = 1'b1; rd_din = 1'b1; wr_cs = 1'b1; wr_din = 1'b1;
  endtask

  // Reset, raise init_done, and return at a falling edge with the DUT in IDLE
  task automatic do_reset;
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge sdclk);
    reset = 1'b0;
    init_done = 1'b1;
    @(negedge sdclk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    clear_inputs();
    @(negedge sdclk);
    checks++; if ({eng_re, eng_we} !== 2'b00) begin failures++; $display("FAIL reset_en: got %b want 00", {eng_re, eng_we}); end
    checks++; if ({rd_ack, wr_ack, rd_fail, wr_fail} !== 4'b0000) begin failures++; $display("FAIL reset_ack: got %b want 0000", {rd_ack, wr_ack, rd_fail, wr_fail}); end
    checks++; if ({cs, din} !== 2'b11) begin failures++; $display("FAIL reset_spi: got %b want 11", {cs, din}); end
    checks++; if (eng_addr !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h want 0", eng_addr); end
    checks++; if ({busy, eng_rst} !== 2'b11) begin failures++; $display("FAIL reset_busy_rst: got %b want 11", {busy, eng_rst}); end
  endtask

  task automatic test_init_wait;
    bit seen;
    reset = 1'b1;
    clear_inputs();
    @(negedge sdclk);
    reset = 1'b0; rd_req = 1'b1; rd_addr = 32'h55;
    seen = 1'b0;
    repeat (100) begin
      @(negedge sdclk);
      if (eng_re !== 1'b0 || busy !== 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL init_wait_hold: got eng_re/idle activity, want none"); end
    init_done = 1'b1;
    @(negedge sdclk);
    checks++; if (eng_re !== 1'b0) begin failures++; $display("FAIL init_lat1: got eng_re=%b want 0", eng_re); end
    @(negedge sdclk);
    checks++; if (eng_re !== 1'b1 || eng_addr !== 32'h55) begin failures++; $display("FAIL init_lat2: got eng_re=%b addr=%h want 1/55", eng_re, eng_addr); end
    rend = 1'b1; #1;
    checks++; if ({rd_ack, rd_fail} !== 2'b10) begin failures++; $display("FAIL init_ack: got %b want 10", {rd_ack, rd_fail}); end
    @(negedge sdclk);
    rend = 1'b0; rd_req = 1'b0;
  endtask

  task automatic test_rr_pair;
    int rd_n, wr_n, g_n;
    logic [32:0] g0, g1;
    bit prev_en, any_fail;
    do_reset();
    rd_n = 0; wr_n = 0; g_n = 0; g0 = '0; g1 = '0; prev_en = 1'b0; any_fail = 1'b0;
    rd_addr = 32'h10; wr_addr = 32'h20; rd_req = 1'b1; wr_req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge sdclk);
      rend = eng_re; wend = eng_we;
      #1;
      if ((eng_re || eng_we) && !prev_en) begin
        if (g_n == 0) g0 = {eng_we, eng_addr};
        else if (g_n == 1) g1 = {eng_we, eng_addr};
        g_n++;
      end
      prev_en = eng_re || eng_we;
      if (rd_ack) begin rd_n++; any_fail |= rd_fail; rd_req = 1'b0; end
      if (wr_ack) begin wr_n++; any_fail |= wr_fail; wr_req = 1'b0; end
    end
    rend = 1'b0; wend = 1'b0;
    checks++; if (g0 !== {1'b0, 32'h10}) begin failures++; $display("FAIL rr_first: got %h want 0_00000010", g0); end
    checks++; if (g1 !== {1'b1, 32'h20}) begin failures++; $display("FAIL rr_second: got %h want 1_00000020", g1); end
    checks++; if (g_n !== 2) begin failures++; $display("FAIL rr_grants: got %0d want 2", g_n); end
    checks++; if (rd_n !== 1 || wr_n !== 1 || any_fail !== 1'b0) begin failures++; $display("FAIL rr_acks: got rd=%0d wr=%0d fail=%b want 1/1/0", rd_n, wr_n, any_fail); end
  endtask

  task automatic test_wr_done;
    bit early;
    do_reset();
    wr_req = 1'b1; wr_addr = $urandom;
    early = 1'b0;
    for (int c = 1; c <= 5000; c++) begin
      @(negedge sdclk);
      if (c == 5000) wend = 1'b1;
      #1;
      if (c < 5000 && (wr_ack !== 1'b0 || eng_we !== 1'b1)) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin failures++; $display("FAIL wr_long_run: early ack or enable drop, want none"); end
    checks++; if ({wr_ack, wr_fail} !== 2'b10) begin failures++; $display("FAIL wr_done_ack: got %b want 10", {wr_ack, wr_fail}); end
    @(negedge sdclk);
    wend = 1'b0; wr_req = 1'b0;
    checks++; if ({eng_we, busy} !== 2'b01) begin failures++; $display("FAIL wr_release1: got we/busy=%b want 01", {eng_we, busy}); end
    @(negedge sdclk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr_release2: got busy=%b want 1", busy); end
    @(negedge sdclk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_wr_err;
    int rst_hi;
    do_reset();
    wr_req = 1'b1; wr_addr = 32'hABCD;
    @(negedge sdclk);
    @(negedge sdclk);
    werr = 1'b1; #1;
    checks++; if ({wr_ack, wr_fail} !== 2'b11) begin failures++; $display("FAIL wr_err_ack: got %b want 11", {wr_ack, wr_fail}); end
    @(negedge sdclk);
    werr = 1'b0; wr_req = 1'b0;
    rst_hi = 0;
    if (eng_rst) rst_hi++;
    @(negedge sdclk);
    if (eng_rst) rst_hi++;
    @(negedge sdclk);
    checks++; if (rst_hi !== 2 || eng_rst !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL wr_err_recover: got rst_cycles=%0d rst=%b busy=%b want 2/0/0", rst_hi, eng_rst, busy); end
    rd_req = 1'b1; rd_addr = 32'h77;
    @(negedge sdclk);
    checks++; if (eng_re !== 1'b1 || eng_addr !== 32'h77) begin failures++; $display("FAIL wr_err_next_rd: got re=%b addr=%h want 1/77", eng_re, eng_addr); end
    rend = 1'b1; #1;
    checks++; if ({rd_ack, rd_fail} !== 2'b10) begin failures++; $display("FAIL wr_err_next_ack: got %b want 10", {rd_ack, rd_fail}); end
    @(negedge sdclk);
    rend = 1'b0; rd_req = 1'b0;
  endtask

  task automatic test_timeout;
    bit early;
    do_reset();
    rd_req = 1'b1; rd_addr = $urandom; rd_cs = 1'b0; rd_din = 1'b1;
    early = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge sdclk);
      #1;
      if (c < 50 && t_rd_ack !== 1'b0) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin failures++; $display("FAIL to_early: ack before cycle 50"); end
    checks++; if ({t_rd_ack, t_rd_fail, t_eng_re} !== 3'b111) begin failures++; $display("FAIL to_ack: got %b want 111", {t_rd_ack, t_rd_fail, t_eng_re}); end
    checks++; if ({t_wr_ack, t_wr_fail, t_eng_we} !== 3'b000 || t_eng_addr !== rd_addr) begin failures++; $display("FAIL to_side: got %b addr=%h", {t_wr_ack, t_wr_fail, t_eng_we}, t_eng_addr); end
    checks++; if (rd_ack !== 1'b0) begin failures++; $display("FAIL to_long_dut: got rd_ack=%b want 0", rd_ack); end
    @(negedge sdclk);
    rd_req = 1'b0;
    #1;
    checks++; if ({t_eng_rst, t_eng_re, t_busy, t_cs, t_din} !== 5'b10101) begin failures++; $display("FAIL to_recover: got %b want 10101", {t_eng_rst, t_eng_re, t_busy, t_cs, t_din}); end
  endtask

  task automatic test_reset_mid;
    bit seen;
    do_reset();
    rd_req = 1'b1; rd_addr = 32'h99; rd_cs = 1'b0;
    repeat (3) @(negedge sdclk);
    checks++; if ({eng_re, cs} !== 2'b10) begin failures++; $display("FAIL mid_pre: got re/cs=%b want 10", {eng_re, cs}); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({cs, eng_re, rd_ack, eng_rst, busy} !== 5'b10011) begin failures++; $display("FAIL mid_reset: got %b want 10011", {cs, eng_re, rd_ack, eng_rst, busy}); end
    @(negedge sdclk);
    reset = 1'b0; init_done = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge sdclk);
      if (eng_re !== 1'b0 || rd_ack !== 1'b0 || busy !== 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mid_init_wait: activity after reset, want INIT_WAIT"); end
    rd_req = 1'b0; rd_cs = 1'b1;
  endtask

  task automatic test_random;
    logic [31:0] a_rd, a_wr, exp_addr;
    bit p_rd, p_wr, last_wr, win_wr, fail_exp;
    int unsigned k, kind, m;
    do_reset();
    last_wr = 1'b1; p_rd = 1'b0; p_wr = 1'b0; a_rd = '0; a_wr = '0;
    for (int t = 0; t < 40; t++) begin
      checks++; if (busy !== 1'b0 || {cs, din} !== 2'b11) begin failures++; $display("FAIL rand_idle[%0d]: busy=%b spi=%b want 0/11", t, busy, {cs, din}); end
      if (!p_rd && !p_wr) begin
        m = $urandom_range(0, 2);
        if (m != 1) begin p_rd = 1'b1; a_rd = $urandom; end
        if (m != 0) begin p_wr = 1'b1; a_wr = $urandom; end
      end
      rd_req = p_rd; wr_req = p_wr; rd_addr = a_rd; wr_addr = a_wr;
      win_wr   = p_wr && (!p_rd || !last_wr);
      last_wr  = win_wr;
      exp_addr = win_wr ? a_wr : a_rd;
      k        = $urandom_range(1, 12);
      kind     = $urandom_range(0, 2);
      fail_exp = (kind != 0);
      for (int c = 1; c <= int'(k); c++) begin
        @(negedge sdclk);
        rd_cs = 1'($urandom); rd_din = 1'($urandom); wr_cs = 1'($urandom); wr_din = 1'($urandom);
        if (c == 1 && $urandom_range(0, 1) == 1) begin
          if (win_wr && !p_rd) begin p_rd = 1'b1; a_rd = $urandom; rd_req = 1'b1; rd_addr = a_rd; end
          else if (!win_wr && !p_wr) begin p_wr = 1'b1; a_wr = $urandom; wr_req = 1'b1; wr_addr = a_wr; end
        end
        if (c == int'(k)) begin
          if (win_wr) begin wend = (kind != 1); werr = (kind != 0); end
          else        begin rend = (kind != 1); rerr = (kind != 0); end
        end
        #1;
        checks++; if ({eng_re, eng_we} !== {!win_wr, win_wr} || eng_addr !== exp_addr) begin failures++; $display("FAIL rand_run[%0d]: en=%b addr=%h want %b/%h", t, {eng_re, eng_we}, eng_addr, {!win_wr, win_wr}, exp_addr); end
        checks++; if ({rd_ack, wr_ack} !== ((c == int'(k)) ? {!win_wr, win_wr} : 2'b00) || (c == int'(k) && (win_wr ? wr_fail : rd_fail) !== fail_exp)) begin failures++; $display("FAIL rand_ack[%0d]: ack=%b fail=%b%b want win_wr=%b last=%0d fail=%b", t, {rd_ack, wr_ack}, rd_fail, wr_fail, win_wr, c == int'(k), fail_exp); end
        checks++; if ({cs, din} !== (win_wr ? {wr_cs, wr_din} : {rd_cs, rd_din})) begin failures++; $display("FAIL rand_mux[%0d]: got %b", t, {cs, din}); end
      end
      @(negedge sdclk);
      rend = 1'b0; rerr = 1'b0; wend = 1'b0; werr = 1'b0;
      if (win_wr) begin p_wr = 1'b0; wr_req = 1'b0; end
      else        begin p_rd = 1'b0; rd_req = 1'b0; end
      for (int p = 0; p < 2; p++) begin
        if (p == 1) @(negedge sdclk);
        rd_cs = 1'($urandom); rd_din = 1'($urandom); wr_cs = 1'($urandom); wr_din = 1'($urandom);
        #1;
        checks++; if ({eng_re, eng_we, rd_ack, wr_ack} !== 4'b0000 || eng_rst !== fail_exp || busy !== 1'b1) begin failures++; $display("FAIL rand_post[%0d]: outs=%b rst=%b busy=%b want 0000/%b/1", t, {eng_re, eng_we, rd_ack, wr_ack}, eng_rst, busy, fail_exp); end
        checks++; if ({cs, din} !== (win_wr ? {wr_cs, wr_din} : {rd_cs, rd_din})) begin failures++; $display("FAIL rand_post_mux[%0d]: got %b", t, {cs, din}); end
      end
      @(negedge sdclk);
    end
    rd_req = 1'b0; wr_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init_wait();
    test_rr_pair();
    test_wr_done();
    test_wr_err();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
